// File: rtl/dino_pkg.sv
// Shared definitions for the Dino game pipeline (controller, obstacle and
// collision stages).
//   - dino_state_e : controller state encodings (visible on the state port)
//   - BCD_W        : width of a 4-digit BCD score
//   - *_DEF        : default parameter values shared across stages
//   - bcd_inc      : saturating 4-digit BCD increment (9999 holds)
//   - bcd_gt       : BCD magnitude compare, most significant digit first
package dino_pkg;

  localparam int BCD_W = 16;

  localparam int SCORE_DIV_DEF    = 6;
  localparam int GRACE_FRAMES_DEF = 2;
  localparam int OVER_LOCK_DEF    = 30;
  localparam int SPEED_STEP_DEF   = 100;
  localparam int MAX_SPEED_DEF    = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_OVER  = 2'b10,
    ST_PAUSE = 2'b11
  } dino_state_e;

  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    logic             carry;
    r     = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    // A carry out of the top digit means v was 9999: hold it.
    if (carry) r = v;
    return r;
  endfunction

  function automatic logic bcd_gt(input logic [BCD_W-1:0] a,
                                  input logic [BCD_W-1:0] b);
    logic done;
    logic gt;
    done = 1'b0;
    gt   = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (!done) begin
        if (a[(3-k)*4 +: 4] > b[(3-k)*4 +: 4]) begin
          gt   = 1'b1;
          done = 1'b1;
        end else if (a[(3-k)*4 +: 4] < b[(3-k)*4 +: 4]) begin
          done = 1'b1;
        end
      end
    end
    return gt;
  endfunction

endpackage

// File: rtl/dino_game_ctrl_if.sv
// Signal bundle between the game controller and its neighbours.
//   crash, frame_tick, btn        : inputs to the controller
//   state, running, jump_req,
//   score, hi_score, speed        : controller outputs
// Modports: master = environment side, slave = controller side.
interface dino_game_ctrl_if;
  import dino_pkg::*;

  logic             crash;
  logic             frame_tick;
  logic             btn;
  logic [1:0]       state;
  logic             running;
  logic             jump_req;
  logic [BCD_W-1:0] score;
  logic [BCD_W-1:0] hi_score;
  logic [2:0]       speed;

  modport master (
    output crash, frame_tick, btn,
    input  state, running, jump_req, score, hi_score, speed
  );

  modport slave (
    input  crash, frame_tick, btn,
    output state, running, jump_req, score, hi_score, speed
  );

endinterface

// File: rtl/bcd_cnt4.sv
// 4-digit BCD counter, saturating at 9999.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset (value -> 0)
//   clr_i  : synchronous clear (wins over inc_i)
//   inc_i  : increment enable
//   val_o  : registered BCD value, digits always 0..9 so it compares
//            directly as a binary magnitude
module bcd_cnt4
  import dino_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [BCD_W-1:0] val_o
);

  logic [BCD_W-1:0] val_q;
  logic [BCD_W-1:0] val_d;

  always_comb begin
    val_d = val_q;
    if (clr_i) begin
      val_d = '0;
    end else if (inc_i) begin
      val_d = bcd_inc(val_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign val_o = val_q;

endmodule

// File: rtl/dino_game_ctrl.sv
// Chrome Dino game-state controller, downstream of the collision detector.
// Sequences IDLE / RUN / OVER (and PAUSE), keeps BCD score and high score,
// and drives the speed level and jump request.
//   clk        : pixel clock
//   rstn       : asynchronous active-low reset
//   btn_pause  : raw pause button (only when DINO_PAUSE_EN is defined)
//   bus        : dino_game_ctrl_if.slave (crash, frame_tick, btn in;
//                state, running, jump_req, score, hi_score, speed out)
// Build option: DINO_PAUSE_EN adds the pause button and the PAUSE state.
module dino_game_ctrl
  import dino_pkg::*;
#(
  parameter int SCORE_DIV    = SCORE_DIV_DEF,
  parameter int GRACE_FRAMES = GRACE_FRAMES_DEF,
  parameter int OVER_LOCK    = OVER_LOCK_DEF,
  parameter int SPEED_STEP   = SPEED_STEP_DEF,
  parameter int MAX_SPEED    = MAX_SPEED_DEF
)
(
  input logic             clk,
  input logic             rstn,
`ifdef DINO_PAUSE_EN
  input logic             btn_pause,
`endif
  dino_game_ctrl_if.slave bus
);

  localparam logic [15:0] DIV_LAST  = 16'(SCORE_DIV - 1);
  localparam logic [15:0] GRACE_END = 16'(GRACE_FRAMES);
  localparam logic [15:0] LOCK_END  = 16'(OVER_LOCK);
  localparam logic [2:0]  SPD_MAX   = 3'(MAX_SPEED);
  // Speed steps are decades, so "multiple of the step" reduces to the low
  // BCD digits being zero.
  localparam int          STEP_DIGITS = (SPEED_STEP >= 1000) ? 3 :
                                        (SPEED_STEP >= 100)  ? 2 : 1;
  localparam logic [BCD_W-1:0] STEP_MASK = BCD_W'((1 << (4*STEP_DIGITS)) - 1);

  dino_state_e      state_q, state_d;
  logic [15:0]      div_q, div_d;
  logic [15:0]      grace_q, grace_d;
  logic [15:0]      lock_q, lock_d;
  logic [2:0]       speed_q, speed_d;
  logic [BCD_W-1:0] hi_q, hi_d;
  logic             jump_q, jump_d;
  logic             running_q;
  logic             score_clr, score_inc;
  logic [BCD_W-1:0] score;
  logic [BCD_W-1:0] score_nxt;
  logic             crash_live;

  // Two synchronizer flops plus a history flop; the edge pulse is registered.
  logic [2:0]       btn_sync_q;
  logic             btn_edge_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      btn_sync_q <= '0;
      btn_edge_q <= 1'b0;
    end else begin
      btn_sync_q <= {btn_sync_q[1:0], bus.btn};
      btn_edge_q <= btn_sync_q[1] & ~btn_sync_q[2];
    end
  end

`ifdef DINO_PAUSE_EN
  logic [2:0]       pause_sync_q;
  logic             pause_edge_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pause_sync_q <= '0;
      pause_edge_q <= 1'b0;
    end else begin
      pause_sync_q <= {pause_sync_q[1:0], btn_pause};
      pause_edge_q <= pause_sync_q[1] & ~pause_sync_q[2];
    end
  end
`endif

  bcd_cnt4 u_score (
    .clk_i  (clk),
    .rst_ni (rstn),
    .clr_i  (score_clr),
    .inc_i  (score_inc),
    .val_o  (score)
  );

  assign score_nxt  = bcd_inc(score);
  assign crash_live = bus.crash && (grace_q >= GRACE_END);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    grace_d   = grace_q;
    lock_d    = lock_q;
    speed_d   = speed_q;
    hi_d      = hi_q;
    jump_d    = 1'b0;
    score_clr = 1'b0;
    score_inc = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (btn_edge_q) begin
          state_d   = ST_RUN;
          score_clr = 1'b1;
          speed_d   = '0;
          div_d     = '0;
          grace_d   = '0;
        end
      end

      ST_RUN: begin
        // Crash pre-empts everything else on this clock: no jump, no score.
        if (crash_live) begin
          state_d = ST_OVER;
          lock_d  = '0;
          if (bcd_gt(score, hi_q)) hi_d = score;
        end
`ifdef DINO_PAUSE_EN
        else if (pause_edge_q) begin
          state_d = ST_PAUSE;
        end
`endif
        else begin
          jump_d = btn_edge_q;
          if (bus.frame_tick) begin
            if (grace_q < GRACE_END) grace_d = grace_q + 16'd1;
            if (div_q >= DIV_LAST) begin
              div_d     = '0;
              score_inc = 1'b1;
              if (score_nxt != score && (score_nxt & STEP_MASK) == '0 &&
                  speed_q < SPD_MAX) begin
                speed_d = speed_q + 3'd1;
              end
            end else begin
              div_d = div_q + 16'd1;
            end
          end
        end
      end

      ST_OVER: begin
        if (bus.frame_tick && lock_q < LOCK_END) lock_d = lock_q + 16'd1;
        if (btn_edge_q && lock_q >= LOCK_END) begin
          state_d   = ST_RUN;
          score_clr = 1'b1;
          speed_d   = '0;
          div_d     = '0;
          grace_d   = '0;
        end
      end

`ifdef DINO_PAUSE_EN
      ST_PAUSE: begin
        if (pause_edge_q) state_d = ST_RUN;
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      grace_q   <= '0;
      lock_q    <= '0;
      speed_q   <= '0;
      hi_q      <= '0;
      jump_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      grace_q   <= grace_d;
      lock_q    <= lock_d;
      speed_q   <= speed_d;
      hi_q      <= hi_d;
      jump_q    <= jump_d;
      running_q <= (state_d == ST_RUN);
    end
  end

  assign bus.state    = state_q;
  assign bus.running  = running_q;
  assign bus.jump_req = jump_q;
  assign bus.score    = score;
  assign bus.hi_score = hi_q;
  assign bus.speed    = speed_q;

endmodule

// File: tb/tb_dino_game_ctrl.sv
// Self-checking bench for dino_game_ctrl. Expected output snapshots come from
// a small behavioural model (integer score, divider, high score) and are
// queued when stimulus is applied, then popped and compared against the DUT.
// Define DINO_PAUSE_EN to also exercise the pause button.
module tb_dino_game_ctrl;
  import dino_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
`ifdef DINO_PAUSE_EN
  logic btn_pause = 1'b0;
`endif

  dino_game_ctrl_if bus();

  dino_game_ctrl #(
    .SCORE_DIV    (6),
    .GRACE_FRAMES (2),
    .OVER_LOCK    (30),
    .SPEED_STEP   (100),
    .MAX_SPEED    (7)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
`ifdef DINO_PAUSE_EN
    .btn_pause (btn_pause),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int jcnt     = 0;

  always @(negedge clk) if (bus.jump_req === 1'b1) jcnt++;

  typedef struct packed {
    logic [1:0]  st;
    logic [15:0] sc;
    logic [15:0] hi;
    logic [2:0]  sp;
    logic [31:0] jc;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];

  // Behavioural model state.
  logic [1:0] st_i  = 2'b00;
  int         sc_i  = 0;
  int         div_i = 0;
  int         hi_i  = 0;
  int         sp_i  = 0;
  int         exp_jc = 0;

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    e.st = st_i;
    e.sc = to_bcd(sc_i);
    e.hi = to_bcd(hi_i);
    e.sp = 3'(sp_i);
    e.jc = 32'(exp_jc);
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_outputs();
    exp_t  e;
    string t;
    if (sb_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      check_val({t, ".state"},    32'(bus.state),    32'(e.st));
      check_val({t, ".running"},  32'(bus.running),  32'(e.st == 2'b01));
      check_val({t, ".score"},    32'(bus.score),    32'(e.sc));
      check_val({t, ".hi_score"}, 32'(bus.hi_score), 32'(e.hi));
      check_val({t, ".speed"},    32'(bus.speed),    32'(e.sp));
      check_val({t, ".jumps"},    32'(jcnt),         e.jc);
    end
  endtask

  task automatic expect_now(input string tag);
    push_exp(tag);
    check_outputs();
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // frame_tick held high for n consecutive clocks = n ticks.
  task automatic run_ticks(input int n);
    bus.frame_tick = 1'b1;
    cyc(n);
    bus.frame_tick = 1'b0;
    if (st_i == 2'b01) begin
      div_i = div_i + n;
      sc_i  = sc_i + div_i / 6;
      div_i = div_i % 6;
      if (sc_i > 9999) sc_i = 9999;
      sp_i  = (sc_i / 100 > 7) ? 7 : sc_i / 100;
    end
  endtask

  task automatic start_model();
    st_i = 2'b01; sc_i = 0; div_i = 0; sp_i = 0;
  endtask

  task automatic press();
    bus.btn = 1'b1;
    cyc(6);
    bus.btn = 1'b0;
    cyc(3);
  endtask

  task automatic crash_pulse();
    bus.crash = 1'b1;
    cyc(1);
    bus.crash = 1'b0;
    st_i = 2'b10;
    if (sc_i > hi_i) hi_i = sc_i;
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    st_i = 2'b00; sc_i = 0; div_i = 0; hi_i = 0; sp_i = 0;
    expect_now(tag);
    @(negedge clk);
    rstn = 1'b1;
    cyc(2);
  endtask

`ifdef DINO_PAUSE_EN
  task automatic press_pause();
    btn_pause = 1'b1;
    cyc(6);
    btn_pause = 1'b0;
    cyc(3);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.crash      = 1'b0;
    bus.frame_tick = 1'b0;
    bus.btn        = 1'b0;

    cyc(3);
    expect_now("reset");
    rstn = 1'b1;
    cyc(2);

    // Start and basic scoring.
    press(); start_model();
    expect_now("idle_to_run");
    run_ticks(12);
    expect_now("score_12_ticks");
    run_ticks(240);
    expect_now("score_0x42");
    async_reset("reset_mid_run");

    // Grace window: stale crash over the first two frames is ignored.
    press(); start_model();
    bus.crash = 1'b1;
    run_ticks(1);
    cyc(2);
    expect_now("grace_frame1");
    run_ticks(1);
    bus.crash = 1'b0;
    expect_now("grace_frame2");
    cyc(2);
    run_ticks(3);
    cyc(2);
    expect_now("run_frame5");
    bus.crash = 1'b1;
    #1;
    expect_now("crash_before_edge");
    @(negedge clk);
    bus.crash = 1'b0;
    st_i = 2'b10;
    expect_now("crash_to_over");

    // Restart after lock, jump in RUN, then set hi to 0x0050.
    run_ticks(30);
    press(); start_model();
    expect_now("restart_from_over");
    press(); exp_jc++;
    expect_now("jump_in_run");
    run_ticks(300);
    crash_pulse();
    expect_now("hi_0x50");

    // Beat the high score with 0x0123.
    run_ticks(30);
    press(); start_model();
    run_ticks(738);
    expect_now("score_0x123");
    crash_pulse();
    expect_now("hi_0x123");
    press();
    expect_now("over_no_jump");
    run_ticks(10);
    press();
    expect_now("btn_locked_frame10");
    run_ticks(21);
    press(); start_model();
    expect_now("btn_after_lock");

    // Button edge coincident with crash: crash wins, no jump.
    run_ticks(2);
    bus.btn = 1'b1;
    cyc(3);
    bus.crash = 1'b1;
    cyc(1);
    bus.crash = 1'b0;
    st_i = 2'b10;
    cyc(3);
    bus.btn = 1'b0;
    cyc(2);
    expect_now("crash_beats_jump");

    // Speed steps and saturation.
    run_ticks(30);
    press(); start_model();
    run_ticks(594);
    expect_now("score_0x99");
    run_ticks(6);
    expect_now("score_0x100_speed1");
    run_ticks(59394);
    expect_now("score_9999");
    run_ticks(12);
    expect_now("score_sat");

    async_reset("reset_clears_hi");

`ifdef DINO_PAUSE_EN
    press(); start_model();
    run_ticks(60);
    expect_now("pre_pause");
    press_pause(); st_i = 2'b11;
    expect_now("paused");
    run_ticks(20);
    bus.crash = 1'b1;
    cyc(2);
    bus.crash = 1'b0;
    press();
    expect_now("pause_frozen");
    press_pause(); st_i = 2'b01;
    expect_now("resumed");
    run_ticks(6);
    expect_now("resumed_counting");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
